// File: rtl/ase_pcie_ss_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ase_pcie_ss_pkg                                        |
// | Description : Shared types for the ASE PCIe SS DMA read completion   |
// |               generator (request/completion descriptors, FSM state). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ase_pcie_ss_pkg;

   localparam int ASE_PCIE_SS_PAGE_BYTES = 4096;
   localparam int ASE_PCIE_SS_DMA_TAG_W  = 10;
   localparam int ASE_PCIE_SS_DMA_ADDR_W = 64;
   localparam int ASE_PCIE_SS_DMA_LEN_W  = 13;

   typedef struct packed {
      logic [ASE_PCIE_SS_DMA_TAG_W-1:0]  tag;
      logic [ASE_PCIE_SS_DMA_ADDR_W-1:0] addr;
      logic [ASE_PCIE_SS_DMA_LEN_W-1:0]  len_bytes;
   } t_ase_pcie_ss_dma_rd_req;

   typedef struct packed {
      logic [ASE_PCIE_SS_DMA_TAG_W-1:0]  tag;
      logic [ASE_PCIE_SS_DMA_ADDR_W-1:0] addr;
      logic [6:0]                        lower_addr;
      logic [ASE_PCIE_SS_DMA_LEN_W-1:0]  len_bytes;
      logic [ASE_PCIE_SS_DMA_LEN_W-1:0]  byte_count;
      logic                              last;
   } t_ase_pcie_ss_dma_rd_cpl;

   typedef enum logic [0:0] {
      CPL_GEN_IDLE = 1'b0,
      CPL_GEN_EMIT = 1'b1
   } t_ase_pcie_ss_cpl_gen_state;

endpackage
`default_nettype wire

// File: rtl/ase_pcie_ss_cpl_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ase_pcie_ss_cpl_req_fifo                               |
// | Description : Synchronous FIFO of DMA read request descriptors with  |
// |               registered full/empty flags.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ase_pcie_ss_cpl_req_fifo
   import ase_pcie_ss_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  t_ase_pcie_ss_dma_rd_req push_data,
   input  logic                    pop,
   output t_ase_pcie_ss_dma_rd_req pop_data,
   output logic                    full,
   output logic                    empty
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]   c_depth   = DEPTH[c_ptr_w:0];
   localparam logic [c_ptr_w:0]   c_cnt_one = 1;
   localparam logic [c_ptr_w-1:0] c_ptr_one = 1;

   t_ase_pcie_ss_dma_rd_req r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic [c_ptr_w:0]   w_count_next;
   logic               r_full;
   logic               r_empty;
   logic               w_push;
   logic               w_pop;

   // A push into a full FIFO is only honoured when a pop frees a slot in the same cycle
   assign w_pop  = pop & ~r_empty;
   assign w_push = push & (~r_full | w_pop);

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + c_cnt_one;
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - c_cnt_one;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
         r_count <= w_count_next;
         r_full  <= (w_count_next == c_depth);
         r_empty <= (w_count_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

   assign pop_data = r_mem[r_rd_ptr];
   assign full     = r_full;
   assign empty    = r_empty;

endmodule
`default_nettype wire

// File: rtl/ase_pcie_ss_dma_rd_cpl_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ase_pcie_ss_dma_rd_cpl_gen                             |
// | Description : Splits AFU DMA read requests into ordered completion   |
// |               descriptors. Define ASE_PCIE_SS_CPL_RCB_ALIGN_EN to    |
// |               align the first chunk to the max payload boundary.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ase_pcie_ss_dma_rd_cpl_gen
   import ase_pcie_ss_pkg::*;
#(
   parameter int ADDR_WIDTH            = 64,
   parameter int TAG_WIDTH             = 10,
   parameter int MAX_RD_REQ_BYTES      = 4096,
   parameter int MAX_CPL_PAYLOAD_BYTES = 256,
   parameter int RCB_BYTES             = 64,
   parameter int FIFO_DEPTH            = 8
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [12:0]           req_len_bytes,
   output logic                  cpl_valid,
   input  logic                  cpl_ready,
   output logic [TAG_WIDTH-1:0]  cpl_tag,
   output logic [ADDR_WIDTH-1:0] cpl_addr,
   output logic [6:0]            cpl_lower_addr,
   output logic [12:0]           cpl_len_bytes,
   output logic [12:0]           cpl_byte_count,
   output logic                  cpl_last,
   output logic                  err_len,
   output logic                  busy
);

   localparam int c_off_w = $clog2(MAX_CPL_PAYLOAD_BYTES);
   localparam logic [12:0] c_max_cpl = MAX_CPL_PAYLOAD_BYTES[12:0];
   localparam logic [12:0] c_max_req = MAX_RD_REQ_BYTES[12:0];
   localparam logic [13:0] c_page    = ASE_PCIE_SS_PAGE_BYTES[13:0];

   generate
      if ((MAX_CPL_PAYLOAD_BYTES % RCB_BYTES) != 0) begin : g_bad_rcb
         $error("MAX_CPL_PAYLOAD_BYTES must be a multiple of RCB_BYTES");
      end
   endgenerate

   t_ase_pcie_ss_cpl_gen_state r_state;
   t_ase_pcie_ss_cpl_gen_state w_state_next;
   t_ase_pcie_ss_dma_rd_cpl    r_cpl;
   t_ase_pcie_ss_dma_rd_cpl    w_cpl_next;
   t_ase_pcie_ss_dma_rd_req    w_push_data;
   t_ase_pcie_ss_dma_rd_req    w_pop_data;

   logic        w_fifo_full;
   logic        w_fifo_empty;
   logic        w_pop;
   logic        w_push;
   logic        w_req_fire;
   logic        w_illegal;
   logic [13:0] w_page_end;
   logic        r_err_len;

   // Builds a completion descriptor for the chunk starting at addr with rem bytes left
   function automatic t_ase_pcie_ss_dma_rd_cpl make_cpl(
      input logic [ASE_PCIE_SS_DMA_TAG_W-1:0]  tag,
      input logic [ASE_PCIE_SS_DMA_ADDR_W-1:0] addr,
      input logic [12:0]                       rem
   );
      t_ase_pcie_ss_dma_rd_cpl c;
      logic [12:0] space;
      logic [12:0] chunk;
`ifdef ASE_PCIE_SS_CPL_RCB_ALIGN_EN
      space = c_max_cpl - 13'(addr[c_off_w-1:0]);
`else
      space = c_max_cpl;
`endif
      chunk        = (rem < space) ? rem : space;
      c.tag        = tag;
      c.addr       = addr;
      c.lower_addr = addr[6:0];
      c.len_bytes  = chunk;
      c.byte_count = rem;
      c.last       = (chunk == rem);
      return c;
   endfunction

   assign w_req_fire = req_valid & req_ready;
   assign w_page_end = {2'b00, req_addr[11:0]} + {1'b0, req_len_bytes};
   assign w_illegal  = (req_len_bytes == '0) || (req_len_bytes > c_max_req) ||
                       (w_page_end > c_page);
   assign w_push     = w_req_fire & ~w_illegal;

   assign w_push_data.tag       = req_tag;
   assign w_push_data.addr      = req_addr;
   assign w_push_data.len_bytes = req_len_bytes;

   ase_pcie_ss_cpl_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .pop_data  (w_pop_data),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty)
   );

   always_comb begin
      w_state_next = r_state;
      w_cpl_next   = r_cpl;
      w_pop        = 1'b0;
      case (r_state)
         CPL_GEN_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop        = 1'b1;
               w_cpl_next   = make_cpl(w_pop_data.tag, w_pop_data.addr, w_pop_data.len_bytes);
               w_state_next = CPL_GEN_EMIT;
            end
         end
         CPL_GEN_EMIT: begin
            if (cpl_ready) begin
               if (r_cpl.last) begin
                  // Chain straight into the next queued request to avoid a bubble
                  if (!w_fifo_empty) begin
                     w_pop      = 1'b1;
                     w_cpl_next = make_cpl(w_pop_data.tag, w_pop_data.addr,
                                           w_pop_data.len_bytes);
                  end else begin
                     w_cpl_next   = '0;
                     w_state_next = CPL_GEN_IDLE;
                  end
               end else begin
                  w_cpl_next = make_cpl(r_cpl.tag,
                                        r_cpl.addr + {{(ASE_PCIE_SS_DMA_ADDR_W-13){1'b0}}, r_cpl.len_bytes},
                                        r_cpl.byte_count - r_cpl.len_bytes);
               end
            end
         end
         default: begin
            w_cpl_next   = '0;
            w_state_next = CPL_GEN_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= CPL_GEN_IDLE;
         r_cpl     <= '0;
         r_err_len <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cpl     <= w_cpl_next;
         r_err_len <= w_req_fire & w_illegal;
      end
   end

   assign req_ready      = ~w_fifo_full;
   assign cpl_valid      = (r_state == CPL_GEN_EMIT);
   assign cpl_tag        = r_cpl.tag;
   assign cpl_addr       = r_cpl.addr;
   assign cpl_lower_addr = r_cpl.lower_addr;
   assign cpl_len_bytes  = r_cpl.len_bytes;
   assign cpl_byte_count = r_cpl.byte_count;
   assign cpl_last       = r_cpl.last;
   assign err_len        = r_err_len;
   assign busy           = ~w_fifo_empty | (r_state != CPL_GEN_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ase_pcie_ss_dma_rd_cpl_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ase_pcie_ss_dma_rd_cpl_gen                          |
// | Description : Directed self-checking bench for the DMA read          |
// |               completion generator.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ase_pcie_ss_dma_rd_cpl_gen;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_tag;
   logic [63:0] req_addr;
   logic [12:0] req_len_bytes;
   logic        cpl_valid;
   logic        cpl_ready;
   logic [9:0]  cpl_tag;
   logic [63:0] cpl_addr;
   logic [6:0]  cpl_lower_addr;
   logic [12:0] cpl_len_bytes;
   logic [12:0] cpl_byte_count;
   logic        cpl_last;
   logic        err_len;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   ase_pcie_ss_dma_rd_cpl_gen dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_tag        (req_tag),
      .req_addr       (req_addr),
      .req_len_bytes  (req_len_bytes),
      .cpl_valid      (cpl_valid),
      .cpl_ready      (cpl_ready),
      .cpl_tag        (cpl_tag),
      .cpl_addr       (cpl_addr),
      .cpl_lower_addr (cpl_lower_addr),
      .cpl_len_bytes  (cpl_len_bytes),
      .cpl_byte_count (cpl_byte_count),
      .cpl_last       (cpl_last),
      .err_len        (err_len),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string nm, input logic [9:0] tag, input logic [63:0] addr,
                       input logic [12:0] len);
      int n;
      req_valid     = 1'b1;
      req_tag       = tag;
      req_addr      = addr;
      req_len_bytes = len;
      n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      check({nm, "_req_ready"}, req_ready, 1);
      tick();
      req_valid = 1'b0;
   endtask

   // Assumes cpl_ready is high; consumes one completion
   task automatic expect_cpl(input string nm, input logic [9:0] tag, input logic [63:0] addr,
                             input logic [12:0] len, input logic [12:0] bc, input logic last,
                             input int max_wait);
      int n;
      logic [63:0] a;
      a = addr;
      n = 0;
      while (!cpl_valid && n < max_wait) begin
         tick();
         n++;
      end
      check({nm, "_valid"}, cpl_valid, 1);
      check({nm, "_tag"}, cpl_tag, tag);
      check({nm, "_addr"}, cpl_addr, a);
      check({nm, "_lower"}, cpl_lower_addr, a[6:0]);
      check({nm, "_len"}, cpl_len_bytes, len);
      check({nm, "_bc"}, cpl_byte_count, bc);
      check({nm, "_last"}, cpl_last, last);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcnt;
      reset         = 1'b1;
      req_valid     = 1'b0;
      req_tag       = '0;
      req_addr      = '0;
      req_len_bytes = '0;
      cpl_ready     = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_cpl_valid", cpl_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err_len", err_len, 0);
      reset = 1'b0;
      tick();
      check("rst_req_ready", req_ready, 1);
      check("rst_cpl_tag", cpl_tag, 0);
      check("rst_cpl_len", cpl_len_bytes, 0);
      check("rst_cpl_bc", cpl_byte_count, 0);
      check("rst_cpl_last", cpl_last, 0);

      // Single aligned request, one completion, one idle cycle of latency
      cpl_ready = 1'b1;
      send("t1", 10'h001, 64'h1000, 13'd256);
      check("t1_lat_idle", cpl_valid, 0);
      check("t1_busy", busy, 1);
      tick();
      expect_cpl("t1_c0", 10'h001, 64'h1000, 13'd256, 13'd256, 1'b1, 0);
      check("t1_done_valid", cpl_valid, 0);

      // Misaligned 512-byte request
      send("t2", 10'h002, 64'h1020, 13'd512);
`ifdef ASE_PCIE_SS_CPL_RCB_ALIGN_EN
      expect_cpl("t2_c0", 10'h002, 64'h1020, 13'd224, 13'd512, 1'b0, 3);
      expect_cpl("t2_c1", 10'h002, 64'h1100, 13'd256, 13'd288, 1'b0, 0);
      expect_cpl("t2_c2", 10'h002, 64'h1200, 13'd32,  13'd32,  1'b1, 0);
`else
      expect_cpl("t2_c0", 10'h002, 64'h1020, 13'd256, 13'd512, 1'b0, 3);
      expect_cpl("t2_c1", 10'h002, 64'h1120, 13'd256, 13'd256, 1'b1, 0);
`endif
      check("t2_done_valid", cpl_valid, 0);

      // Illegal requests: zero length, oversize, page crossing
      send("t3a", 10'h030, 64'h0000, 13'd0);
      check("t3a_err", err_len, 1);
      tick();
      check("t3a_err_clr", err_len, 0);
      send("t3b", 10'h031, 64'h0000, 13'd4097);
      check("t3b_err", err_len, 1);
      tick();
      check("t3b_err_clr", err_len, 0);
      send("t3c", 10'h032, 64'h1F80, 13'd256);
      check("t3c_err", err_len, 1);
      vcnt = 0;
      repeat (3) begin
         tick();
         if (cpl_valid) vcnt++;
      end
      check("t3_no_cpl", vcnt, 0);
      check("t3_busy", busy, 0);
      check("t3_err_clr", err_len, 0);

      // Page-end boundary is legal
      send("t3d", 10'h033, 64'h1F00, 13'd256);
      check("t3d_no_err", err_len, 0);
      expect_cpl("t3d_c0", 10'h033, 64'h1F00, 13'd256, 13'd256, 1'b1, 3);

      // Back-pressure fill: 1 in the FSM plus FIFO_DEPTH queued, then blocked
      cpl_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         req_valid     = 1'b1;
         req_tag       = 10'(10'h010 + i);
         req_addr      = 64'h4000 + 64'(i * 64);
         req_len_bytes = 13'd64;
         check($sformatf("t4_ready_%0d", i), req_ready, (i < 9) ? 1 : 0);
         if (i < 9) tick();
      end
      check("t4_busy", busy, 1);
      cpl_ready = 1'b1;
      expect_cpl("t4_c0", 10'h010, 64'h4000, 13'd64, 13'd64, 1'b1, 0);
      check("t4_ready_after_pop", req_ready, 1);
      expect_cpl("t4_c1", 10'h011, 64'h4040, 13'd64, 13'd64, 1'b1, 0);
      req_valid = 1'b0;
      for (int i = 2; i < 10; i++) begin
         expect_cpl($sformatf("t4_c%0d", i), 10'(10'h010 + i), 64'h4000 + 64'(i * 64),
                    13'd64, 13'd64, 1'b1, 0);
      end
      check("t4_drained_busy", busy, 0);

      // Stall mid-request
      send("t5", 10'h005, 64'h2000, 13'd512);
      expect_cpl("t5_c0", 10'h005, 64'h2000, 13'd256, 13'd512, 1'b0, 3);
      cpl_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t5_hold%0d_valid", i), cpl_valid, 1);
         check($sformatf("t5_hold%0d_addr", i), cpl_addr, 64'h2100);
         check($sformatf("t5_hold%0d_len", i), cpl_len_bytes, 13'd256);
         check($sformatf("t5_hold%0d_bc", i), cpl_byte_count, 13'd256);
         check($sformatf("t5_hold%0d_last", i), cpl_last, 1);
         tick();
      end
      cpl_ready = 1'b1;
      expect_cpl("t5_c1", 10'h005, 64'h2100, 13'd256, 13'd256, 1'b1, 0);

      // Reset during the second chunk with another request queued
      send("t6a", 10'h006, 64'h3000, 13'd512);
      send("t6b", 10'h007, 64'h3400, 13'd128);
      expect_cpl("t6_c0", 10'h006, 64'h3000, 13'd256, 13'd512, 1'b0, 3);
      reset = 1'b1;
      #1;
      check("t6_rst_valid", cpl_valid, 0);
      check("t6_rst_busy", busy, 0);
      tick();
      reset = 1'b0;
      vcnt = 0;
      repeat (10) begin
         tick();
         if (cpl_valid) vcnt++;
      end
      check("t6_no_cpl_after_rst", vcnt, 0);
      check("t6_busy", busy, 0);
      check("t6_req_ready", req_ready, 1);
      check("t6_bc_zero", cpl_byte_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
